sram_arbiter: RTL

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter in front of an asynchronous SRAM: one access at a
// time, strobe held for WAIT_CYCLES, then a one-cycle DONE with the winner's ack.
module sram_arbiter #(
    parameter int unsigned WAIT_CYCLES = 2  // legal range 1..15
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [19:0] addr0,
    input  logic [19:0] addr1,
    input  logic [15:0] wdata0,
    input  logic [15:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic [15:0] rdata,
    output logic        busy,
    output logic        CE,
    output logic        UB,
    output logic        LB,
    output logic        OE,
    output logic        WE,
    output logic [19:0] ADDR,
    output logic [15:0] Data_to_SRAM,
    input  logic [15:0] Data_from_SRAM,
    output logic        tristate_oe
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        winner_q, winner_d;
    logic        last_grant_q, last_grant_d;
    logic        we_q, we_d;
    logic [19:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic        grant;

    // On a tie the port that did not win last time goes next.
    assign grant = (req0 && req1) ? ~last_grant_q : req1;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            winner_q     <= 1'b0;
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            winner_q     <= winner_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        winner_d     = winner_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        CE           = 1'b1;
        UB           = 1'b1;
        LB           = 1'b1;
        OE           = 1'b1;
        WE           = 1'b1;
        tristate_oe  = 1'b0;
        ack0         = 1'b0;
        ack1         = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    winner_d     = grant;
                    last_grant_d = grant;
                    we_d         = grant ? we1 : we0;
                    addr_d       = grant ? addr1 : addr0;
                    wdata_d      = grant ? wdata1 : wdata0;
                    cnt_d        = CNT_INIT;
                    state_d      = ACCESS;
                end
            end
            ACCESS: begin
                CE = 1'b0;
                UB = 1'b0;
                LB = 1'b0;
                if (we_q) begin
                    WE          = 1'b0;
                    tristate_oe = 1'b1;
                end else begin
                    OE = 1'b0;
                end
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = DONE;
                    if (!we_q) rdata_d = Data_from_SRAM;
                end
            end
            DONE: begin
                // Keep driving the bus one more cycle after a write for hold time.
                tristate_oe = we_q;
                ack0        = ~winner_q;
                ack1        = winner_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy         = (state_q != IDLE);
    assign ADDR         = addr_q;
    assign Data_to_SRAM = wdata_q;
    assign rdata        = rdata_q;

endmodule
